mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle HI/LO multiply unit for the MIPS datapath; sits beside the ALU in the execute stage and is started by the decoder's MulOp path. It runs radix-2 shift-add multiplication over WIDTH cycles and owns the HI/LO register pair. It supports mult, multu, madd, msub, mthi and mtlo. It also stalls the pipeline while a result is pending.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  request an operation this cycle
- Op  input  3  000 mult, 001 multu, 010 madd, 011 msub, 100 mthi, 101 mtlo; 110/111 are ignored
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- Flush  input  1  abort the operation in flight
- HiLoRead  input  1  decode stage holds mfhi/mflo
- Busy  output  1  operation in flight (MUL or FIX state)
- Done  output  1  one-cycle pulse in the FIX cycle
- Stall  output  1  hold the front end
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

## Operation
- States: IDLE, MUL, FIX.
- **IDLE**
  - With Start and a multiply op (000–011) and no Flush:
    - latch |A| and |B|; signed for 000/010/011, raw for 001;
    - record the product sign and the Op;
    - clear the product accumulator and set count=0;
    - go to MUL.
  - With Start and op 100/101:
    - write A into Hi or Lo at that edge;
    - stay in IDLE; no Busy, no Done.
  - Other Op values are ignored.
- **MUL**
  - Each cycle: if multiplier bit0 is set, add the multiplicand into the upper half of the 2·WIDTH accumulator (with carry-out).
  - Then shift the accumulator right by 1 and increment count.
  - After count reaches WIDTH−1 (WIDTH cycles total), go to FIX.
- **FIX**
  - Negate the product if the recorded sign is negative.
  - Result P: mult/multu use P; madd uses {Hi,Lo}+P; msub uses {Hi,Lo}−P, modulo 2^(2·WIDTH).
  - Write {Hi,Lo} at the edge ending FIX, then go to IDLE.
- **Start while Busy**: ignored; the op is neither queued nor latched.
- **Flush**
  - In MUL or FIX: go to IDLE at that edge with no write to Hi/Lo. This includes Flush asserted in the FIX cycle; Done is still high in that cycle.
  - In IDLE, Flush blocks a same-cycle Start, including mthi/mtlo.
- **Stall** = Busy & (Start | HiLoRead), combinational.
- **Reset**
  - Rst forces IDLE and clears every output: Hi=0, Lo=0, Busy=0, Done=0, Stall=0.
  - Rst mid-operation discards the operation.

## Timing
- Start accepted at edge E0.
- MUL occupies the cycles after E0 through E32 (WIDTH cycles).
- FIX occupies the next cycle: Busy=1 and Done=1.
- Hi/Lo show the new result from the cycle after FIX, i.e. edge E0+WIDTH+1 writes them. Total WIDTH+2 cycles from the Start cycle to result visibility.
- Busy and Done are registered, decoded from state.
- mthi/mtlo take effect on the edge they are accepted.
- A new Start is accepted in the first IDLE cycle after FIX, so back-to-back operations can run without a gap cycle.
- A HiLoRead in the FIX cycle stalls; the read sees the new value in the following cycle.

## Configuration
- MULSEQ_MADD_EN
  - Defined: madd/msub accumulate as described.
  - Undefined: Op 010/011 are treated like 110/111: Start is ignored, Busy stays low and Hi/Lo are unchanged. The accumulate adder/subtractor is not built.

## Test plan
- mult A=FFFFFFFD (−3), B=5:
  - Done high exactly in cycle 33 after the Start cycle;
  - then Hi=FFFFFFFF, Lo=FFFFFFF1.
- multu A=B=FFFFFFFF → Hi=FFFFFFFE, Lo=00000001; a repeat as signed mult gives Hi=0, Lo=1.
- mthi 0, mtlo 0000000A, then madd 2·3 → Hi=0, Lo=10.
- From Hi=Lo=0, msub 1·1 → Hi=Lo=FFFFFFFF.
- Without MULSEQ_MADD_EN, the madd from the third scenario → Busy stays 0; Hi=0, Lo=A.
- Flush and reset:
  - mult 7·7 with Flush in cycle 10 → Busy low the next cycle; Hi/Lo keep their prior values.
  - Rst asserted mid-MUL → all outputs 0 immediately, without waiting for a clock edge.
- Stall and Start during Busy:
  - HiLoRead held during Busy → Stall=1 in every Busy cycle and 0 after FIX.
  - A second Start (multu 2·2) during Busy → ignored; the first result is intact.

Source files
------------

// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier owning the HI/LO pair (mult/multu/madd/msub/mthi/mtlo).
// Build option: define MULSEQ_MADD_EN to include the madd/msub accumulate path.
module mul_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiLoRead,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MULSEQ_MADD_EN
    logic [1:0]       op_q, op_d;
`endif

    logic             mul_op;
    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    res;

    // Operand magnitudes, partial-sum adder and final sign/accumulate result
    always_comb begin
        signed_op = (Op != 3'b001);
`ifdef MULSEQ_MADD_EN
        mul_op    = (Op[2] == 1'b0);
`else
        mul_op    = (Op[2:1] == 2'b00);
`endif
        a_mag = (signed_op && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag = (signed_op && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        sum   = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod  = neg_q ? (~acc_q + PW'(1)) : acc_q;
        res   = prod;
`ifdef MULSEQ_MADD_EN
        case (op_q)
            2'b10:   res = {hi_q, lo_q} + prod;
            2'b11:   res = {hi_q, lo_q} - prod;
            default: res = prod;
        endcase
`endif
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULSEQ_MADD_EN
        op_d    = op_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    if (mul_op) begin
                        mcand_d = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        neg_d   = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        count_d = '0;
                        state_d = S_MUL;
`ifdef MULSEQ_MADD_EN
                        op_d    = Op[1:0];
`endif
                    end else if (Op == 3'b100) begin
                        hi_d = A;
                    end else if (Op == 3'b101) begin
                        lo_d = A;
                    end
                end
            end
            S_MUL: begin
                // Multiplier sits in the low half and is consumed as the sum shifts in
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
                if (Flush) begin
                    state_d = S_IDLE;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Flush) begin
                    hi_d = res[PW-1:WIDTH];
                    lo_d = res[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIX);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULSEQ_MADD_EN
            op_q    <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULSEQ_MADD_EN
            op_q    <= op_d;
`endif
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign Stall = busy_q & (Start | HiLoRead);

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: driver pushes expected {Hi,Lo}, monitor checks after each Done.
// Honours MULSEQ_MADD_EN the same way as the design.
module tb_mul_sequencer;

`ifdef MULSEQ_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        HiLoRead;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model;
    logic [63:0] mon_e;

    mul_sequencer #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .HiLoRead(HiLoRead), .Busy(Busy), .Done(Done),
        .Stall(Stall), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural HI/LO value
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint sp;
        sp = longint'($signed(a)) * longint'($signed(b));
        case (op)
            3'd0:    return 64'(sp);
            3'd1:    return {32'b0, a} * {32'b0, b};
            3'd2:    return cur + 64'(sp);
            3'd3:    return cur - 64'(sp);
            default: return cur;
        endcase
    endfunction

    // Monitor: HI/LO must hold the queued expectation the cycle after Done
    initial begin
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                @(negedge Clk);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_hilo", {Hi, Lo}, mon_e);
                end
            end
        end
    end

    // flush_at: 0 none, -1 Flush with the Start, 1..33 Flush in that busy cycle
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int start2_at, input logic hlr);
        logic        is_mul;
        logic [63:0] expv;
        int          last;
        is_mul = (flush_at >= 0) && ((op <= 3'd1) || (MADD_EN && (op == 3'd2 || op == 3'd3)));
        expv   = ref_result(op, a, b, model);
        HiLoRead = hlr;
        Start = 1'b1; Op = op; A = a; B = b; Flush = (flush_at < 0);
        @(negedge Clk);
        chk("idle_busy", Busy, 0);
        chk("idle_stall", Stall, 0);
        @(posedge Clk); #1;
        Start = 1'b0; Flush = 1'b0;
        if (!is_mul) begin
            if (flush_at >= 0 && op == 3'd4) model[63:32] = a;
            else if (flush_at >= 0 && op == 3'd5) model[31:0] = a;
            chk("nonmul_busy", Busy, 0);
            chk("nonmul_hilo", {Hi, Lo}, model);
        end else begin
            if (flush_at == 0) exp_q.push_back(expv);
            else if (flush_at == 33) exp_q.push_back(model);
            last = (flush_at > 0 && flush_at < 33) ? flush_at : 33;
            for (int cyc = 1; cyc <= last; cyc++) begin
                if (cyc == flush_at) Flush = 1'b1;
                if (cyc == start2_at) begin
                    Start = 1'b1; Op = 3'd1; A = 32'd2; B = 32'd2;
                end
                @(negedge Clk);
                chk("busy_inflight", Busy, 1);
                chk("done_timing", Done, 64'(cyc == 33));
                chk("stall", Stall, 64'(Start | HiLoRead));
                @(posedge Clk); #1;
                Flush = 1'b0; Start = 1'b0;
            end
            chk("busy_after", Busy, 0);
            chk("done_after", Done, 0);
            chk("stall_after", Stall, 0);
            if (flush_at == 0) model = expv;
            else if (flush_at < 33) chk("hilo_kept_after_flush", {Hi, Lo}, model);
        end
    endtask

    task automatic reset_mid_mul();
        HiLoRead = 1'b1;
        Start = 1'b1; Op = 3'd0; A = 32'd7; B = 32'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        chk("busy_before_rst", Busy, 1);
        chk("stall_before_rst", Stall, 1);
        Rst = 1'b1;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_hilo", {Hi, Lo}, 0);
        @(posedge Clk); #1;
        Rst = 1'b0; HiLoRead = 1'b0;
        model = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Start = 1'b1; Flush = 1'b0; HiLoRead = 1'b1;
        Op = 3'd0; A = '0; B = '0; model = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_stall", Stall, 0);
        chk("reset_hilo", {Hi, Lo}, 0);
        Start = 1'b0; HiLoRead = 1'b0; Rst = 1'b0;

        do_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 0, 1'b0);
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
        do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
        do_op(3'd0, 32'h80000000, 32'h80000000, 0, 0, 1'b0);
        do_op(3'd4, 32'h0, 32'h0, 0, 0, 1'b0);
        do_op(3'd5, 32'hA, 32'h0, 0, 0, 1'b0);
        do_op(3'd2, 32'd2, 32'd3, 0, 0, 1'b0);
        do_op(3'd4, 32'h0, 32'h0, 0, 0, 1'b0);
        do_op(3'd5, 32'h0, 32'h0, 0, 0, 1'b0);
        do_op(3'd3, 32'd1, 32'd1, 0, 0, 1'b0);
        do_op(3'd4, 32'h12345678, 32'h0, -1, 0, 1'b0);
        do_op(3'd0, 32'd7, 32'd7, 10, 0, 1'b0);
        do_op(3'd1, 32'hDEADBEEF, 32'h1234, 33, 0, 1'b1);
        do_op(3'd0, 32'h00010001, 32'hFFFF0003, 0, 5, 1'b1);
        do_op(3'd6, 32'h55, 32'h66, 0, 0, 1'b0);
        do_op(3'd7, 32'h77, 32'h88, 0, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            int          rfl;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rfl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
            do_op(rop, ra, rb, rfl, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        end

        reset_mid_mul();
        do_op(3'd0, 32'd3, 32'hFFFFFFFC, 0, 0, 1'b0);

        repeat (3) @(posedge Clk);
        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
